// File: rtl/fc_pkg.sv
// Shared types and constants for the FC layer sequencer.
// Holds the FSM state encoding and the float constants used by the PE datapath.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } fc_state_e;

    localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;
    localparam logic [31:0] FLOAT_ONE  = 32'h3F80_0000;

    // Extra drain cycles beyond the PE pipeline: one for the buffer read, one for the operand register.
    localparam int DRAIN_EXTRA = 2;

endpackage

// File: rtl/fc_operand_stage.sv
// Operand register stage between the input/weight buffers and the PE array.
// Operands are zero outside the read window, so the PEs accumulate nothing while idle.
module fc_operand_stage
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 32
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        flush,
    input  logic                        rd_en,
    input  logic [DATA_WIDTH-1:0]       in_rd_data,
    input  logic [DATA_WIDTH*LANES-1:0] w_rd_data,
    output logic [DATA_WIDTH-1:0]       input_fc,
    output logic [DATA_WIDTH*LANES-1:0] weightCaches_fc
);

    localparam logic [DATA_WIDTH-1:0] ZERO_WORD = DATA_WIDTH'(FLOAT_ZERO);

    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] input_fc_reg;

    // Read data arrives one cycle after the strobe, so the flag lines up with it.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush || !valid_reg) begin
            input_fc_reg <= ZERO_WORD;
        end else begin
            input_fc_reg <= in_rd_data;
        end
    end

    assign input_fc = input_fc_reg;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0] weight_reg;

        always_ff @(posedge clk) begin
            if (srst || flush || !valid_reg) begin
                weight_reg <= ZERO_WORD;
            end else begin
                weight_reg <= w_rd_data[DATA_WIDTH*gi +: DATA_WIDTH];
            end
        end

        assign weightCaches_fc[DATA_WIDTH*gi +: DATA_WIDTH] = weight_reg;
    end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Sequences one fully-connected layer pass: clear PEs, stream N operands, drain, capture.
// Sits between the layer control FSM and the parallel FC PE array.
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int parallel_fc_PE = 32,
    parameter int DATA_WIDTH_OUT = 32,
    parameter int ADDR_W         = 10,
    parameter int PE_LATENCY     = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [ADDR_W:0]                      num_inputs,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 in_rd_en,
    output logic [ADDR_W-1:0]                    in_rd_addr,
    input  logic [DATA_WIDTH-1:0]                in_rd_data,
    output logic                                 w_rd_en,
    output logic [ADDR_W-1:0]                    w_rd_addr,
    input  logic [DATA_WIDTH*parallel_fc_PE-1:0] w_rd_data,
    output logic [DATA_WIDTH-1:0]                input_fc,
    output logic [DATA_WIDTH*parallel_fc_PE-1:0] weightCaches_fc,
    output logic                                 start_FC,
    input  logic [parallel_fc_PE*DATA_WIDTH_OUT-1:0] output_fc,
    output logic [parallel_fc_PE*DATA_WIDTH_OUT-1:0] result,
    output logic                                 result_valid
);

    localparam int DRAIN_CYCLES = PE_LATENCY + DRAIN_EXTRA;
    localparam int DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    fc_state_e                                  state_reg;
    fc_state_e                                  state_next;
    logic [ADDR_W:0]                            count_reg;
    logic [ADDR_W:0]                            n_reg;
    logic [DRAIN_W-1:0]                         drain_cnt_reg;
    logic [parallel_fc_PE*DATA_WIDTH_OUT-1:0]   result_reg;
    logic                                       result_valid_reg;
    logic                                       rd_en;
    logic                                       accept;
    logic                                       cancel;

    // abort beats a simultaneous start; it only cancels an active pass.
    assign accept = (state_reg == IDLE) && start && !abort;
    assign cancel = (state_reg != IDLE) && abort;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = CLEAR;
            CLEAR:   state_next = (n_reg == '0) ? DRAIN : STREAM;
            STREAM:  if (count_reg == n_reg - 1'b1) state_next = DRAIN;
            DRAIN:   if (drain_cnt_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (cancel) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            count_reg        <= '0;
            n_reg            <= '0;
            drain_cnt_reg    <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        n_reg            <= num_inputs;
                        result_valid_reg <= 1'b0;
                    end
                end
                CLEAR: begin
                    count_reg     <= '0;
                    drain_cnt_reg <= DRAIN_LOAD;
                end
                STREAM: count_reg <= count_reg + 1'b1;
                DRAIN: begin
                    drain_cnt_reg <= drain_cnt_reg - 1'b1;
                    // Captured on the DRAIN->DONE edge so result is already valid while done is high.
                    if (drain_cnt_reg == '0) begin
                        result_reg       <= output_fc;
                        result_valid_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (cancel) begin
                count_reg        <= '0;
                result_reg       <= '0;
                result_valid_reg <= 1'b0;
            end
        end
    end

    assign rd_en        = (state_reg == STREAM);
    assign busy         = (state_reg != IDLE);
    assign done         = (state_reg == DONE);
    assign start_FC     = (state_reg == CLEAR);
    assign in_rd_en     = rd_en;
    assign w_rd_en      = rd_en;
    assign in_rd_addr   = rd_en ? count_reg[ADDR_W-1:0] : '0;
    assign w_rd_addr    = in_rd_addr;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;

    fc_operand_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (parallel_fc_PE)
    ) u_operand_stage (
        .clk             (clk),
        .srst            (reset),
        .flush           (cancel),
        .rd_en           (rd_en),
        .in_rd_data      (in_rd_data),
        .w_rd_data       (w_rd_data),
        .input_fc        (input_fc),
        .weightCaches_fc (weightCaches_fc)
    );

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench for fc_layer_sequencer with buffer memories and an integer-valued float PE model.
// Expected sums come from plain dot products over the stimulus arrays.
module tb_fc_layer_sequencer;

    localparam int DW   = 32;
    localparam int P    = 32;
    localparam int DWO  = 32;
    localparam int AW   = 10;
    localparam int LAT  = 4;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              reset, start, abort;
    logic [AW:0]       num_inputs;
    logic              busy, done, in_rd_en, w_rd_en, start_FC, result_valid;
    logic [AW-1:0]     in_rd_addr, w_rd_addr;
    logic [DW-1:0]     in_rd_data, input_fc;
    logic [DW*P-1:0]   w_rd_data, weightCaches_fc;
    logic [P*DWO-1:0]  output_fc, result;

    always #5 clk = ~clk;

    fc_layer_sequencer #(
        .DATA_WIDTH(DW), .parallel_fc_PE(P), .DATA_WIDTH_OUT(DWO), .ADDR_W(AW), .PE_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .num_inputs(num_inputs),
        .busy(busy), .done(done),
        .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .input_fc(input_fc), .weightCaches_fc(weightCaches_fc), .start_FC(start_FC),
        .output_fc(output_fc), .result(result), .result_valid(result_valid)
    );

    function automatic logic [31:0] i2f(input int v);
        int p;
        logic [31:0] m;
        if (v <= 0) return 32'h0;
        p = 0;
        for (int b = 0; b < 24; b++) if (((v >> b) & 1) != 0) p = b;
        m = 32'(v) << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic int f2i(input logic [31:0] f);
        int e;
        logic [31:0] mant;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        mant = {8'h0, 1'b1, f[22:0]};
        if (e < 0) return 0;
        return int'(mant >> (23 - e));
    endfunction

    // Buffers with one-cycle registered read
    logic [DW-1:0]   in_mem [DEPTH];
    logic [DW*P-1:0] w_mem  [DEPTH];
    always @(posedge clk) begin
        if (in_rd_en) in_rd_data <= in_mem[in_rd_addr];
        if (w_rd_en)  w_rd_data  <= w_mem[w_rd_addr];
    end

    // PE array: accumulate register plus three pipeline stages = 4 cycles to output
    int acc [P];
    int pipe0 [P];
    int pipe1 [P];
    int pipe2 [P];
    always @(posedge clk) begin
        for (int i = 0; i < P; i++) begin
            acc[i]   <= start_FC ? 0 : acc[i] + f2i(input_fc) * f2i(weightCaches_fc[i*DW +: DW]);
            pipe0[i] <= acc[i];
            pipe1[i] <= pipe0[i];
            pipe2[i] <= pipe1[i];
        end
    end
    always_comb begin
        output_fc = '0;
        for (int i = 0; i < P; i++) output_fc[i*DWO +: DWO] = i2f(pipe2[i]);
    end

    int n_vec = 0;
    int n_err = 0;
    int in_val [DEPTH];
    int w_val  [DEPTH][P];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int n;
        int abort_k;
        bit noise;
        bit basic;
    } vec_t;

    task automatic run_pass(input int n, input int abort_k, input bit noise, input bit basic);
        int exp_sum [P];
        int done_k = -1, done_cnt = 0, proto_bad = 0, op_bad = 0, busy_bad = 0;
        bit aborted = 0;
        bit exp_rd;
        logic [DW-1:0]   exp_in;
        logic [DW*P-1:0] exp_w;
        for (int i = 0; i < P; i++) exp_sum[i] = 0;
        for (int a = 0; a < n; a++) begin
            in_val[a] = basic ? 1 : int'($urandom_range(0, 7));
            in_mem[a] = i2f(in_val[a]);
            for (int i = 0; i < P; i++) begin
                w_val[a][i] = basic ? i : int'($urandom_range(0, 7));
                w_mem[a][i*DW +: DW] = i2f(w_val[a][i]);
                exp_sum[i] += in_val[a] * w_val[a][i];
            end
        end
        @(negedge clk);
        num_inputs = (AW+1)'(n);
        start = 1'b1;
        for (int k = 1; k <= n + 12; k++) begin
            @(negedge clk);
            if (abort) begin
                abort = 1'b0;
                aborted = 1'b1;
                check($sformatf("abort_busy n=%0d", n), 64'(busy), 64'(0));
                check($sformatf("abort_rd_en n=%0d", n), 64'({in_rd_en, w_rd_en}), 64'(0));
                check($sformatf("abort_result_valid n=%0d", n), 64'(result_valid), 64'(0));
                check($sformatf("abort_operand n=%0d", n), 64'(input_fc), 64'(0));
                check($sformatf("abort_result_zero n=%0d", n), 64'(result == '0), 64'(1));
            end else if (!aborted) begin
                exp_rd = (k >= 2) && (k <= n + 1);
                if (start_FC !== (k == 1)) proto_bad++;
                if (in_rd_en !== exp_rd || w_rd_en !== exp_rd) proto_bad++;
                if (exp_rd && (int'(in_rd_addr) != k - 2 || w_rd_addr !== in_rd_addr)) proto_bad++;
                if (busy !== (k <= n + 8)) busy_bad++;
                if (result_valid !== (k >= n + 8)) busy_bad++;
                if (k >= 4 && k <= n + 3) begin
                    exp_in = in_mem[k-4];
                    exp_w  = w_mem[k-4];
                end else begin
                    exp_in = '0;
                    exp_w  = '0;
                end
                if (input_fc !== exp_in || weightCaches_fc !== exp_w) op_bad++;
            end
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            start = noise && (k == 3 || k == n + 8);
            if (k == abort_k) abort = 1'b1;
        end
        start = 1'b0;
        if (abort_k > 0) begin
            check($sformatf("abort_no_done n=%0d", n), 64'(done_cnt), 64'(0));
            check($sformatf("abort_valid_after n=%0d", n), 64'(result_valid), 64'(0));
        end else begin
            check($sformatf("done_cycle n=%0d", n), 64'(done_k), 64'(n + LAT + 4));
            check($sformatf("done_count n=%0d", n), 64'(done_cnt), 64'(1));
            check($sformatf("read_protocol n=%0d", n), 64'(proto_bad), 64'(0));
            check($sformatf("operand_window n=%0d", n), 64'(op_bad), 64'(0));
            check($sformatf("busy_valid n=%0d", n), 64'(busy_bad), 64'(0));
            for (int i = 0; i < P; i++)
                check($sformatf("result n=%0d lane %0d", n, i), 64'(result[i*DWO +: DWO]), 64'(i2f(exp_sum[i])));
        end
    endtask

    vec_t vecs [11];

    initial begin
        vecs[0] = '{4, -1, 0, 1};
        vecs[1] = '{3, -1, 0, 0};
        vecs[2] = '{0, -1, 0, 0};
        vecs[3] = '{8, 4, 0, 0};
        vecs[4] = '{2, -1, 0, 0};
        vecs[5] = '{6, -1, 1, 0};
        vecs[6] = '{DEPTH, -1, 0, 1};
        for (int v = 7; v < 11; v++)
            vecs[v] = '{int'($urandom_range(1, 40)), -1, 1'($urandom_range(0, 1)), 1'b0};

        reset = 1'b1; start = 1'b0; abort = 1'b0; num_inputs = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({busy, done, in_rd_en, w_rd_en, start_FC, result_valid}), 64'(0));
        check("reset_data", 64'(result == '0 && input_fc == '0 && weightCaches_fc == '0
                               && in_rd_addr == '0 && w_rd_addr == '0), 64'(1));
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            run_pass(vecs[v].n, vecs[v].abort_k, vecs[v].noise, vecs[v].basic);
            if (v == 0) begin
                check("basic_lane3", 64'(result[3*DWO +: DWO]), 64'(32'h4140_0000));
                check("basic_lane1", 64'(result[1*DWO +: DWO]), 64'(32'h4080_0000));
            end
        end

        // abort together with start in IDLE: start is dropped
        @(negedge clk);
        abort = 1'b1; start = 1'b1; num_inputs = (AW+1)'(5);
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_start_idle_busy", 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
        check("abort_start_idle_later", 64'({busy, start_FC}), 64'(0));

        // reset in the middle of DRAIN
        num_inputs = (AW+1)'(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        check("midreset_ctrl", 64'({busy, done, in_rd_en, w_rd_en, start_FC, result_valid}), 64'(0));
        check("midreset_data", 64'(result == '0 && input_fc == '0 && weightCaches_fc == '0), 64'(1));
        reset = 1'b0;
        @(negedge clk);
        run_pass(3, -1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
